// File: rtl/split_head_scheduler.sv
// Streams a row-major [ROWS][HEADS*HEAD_DIM] tensor and tags each beat with its head-major
// [HEADS][ROWS][HEAD_DIM] destination address. Optional stall counter: SPLIT_SCHED_PERF_EN.
module split_head_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 128,
  parameter int HEADS      = 12,
  parameter int HEAD_DIM   = 64,
  parameter int BEAT_ELEMS = 16,
  parameter int ROW_W      = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                             clk_p,
  input  logic                             rst_p,
  input  logic                             start,
  input  logic [ROW_W-1:0]                 cfg_rows,
  output logic                             busy,
  output logic                             done,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH*BEAT_ELEMS-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*BEAT_ELEMS-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]            out_addr,
  output logic [$clog2(HEADS)-1:0]         out_head,
  output logic                             out_last
`ifdef SPLIT_SCHED_PERF_EN
  ,
  output logic [31:0]                      perf_stall
`endif
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | accepting input beats
  // FLUSH | last beat captured, waiting for downstream to take it
  // DONE  | one-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  localparam int BPH    = HEAD_DIM / BEAT_ELEMS;
  localparam int BEAT_W = (BPH > 1) ? $clog2(BPH) : 1;
  localparam int HEAD_W = $clog2(HEADS);
  localparam int ROW_W1 = ROW_W + 1;
  localparam logic [ROW_W:0] ROWS_EXT = ROW_W1'(ROWS);

  state_t state_q, state_d;

  logic [BEAT_W-1:0]     beat_q;
  logic [HEAD_W-1:0]     head_q;
  logic [ROW_W-1:0]      row_q;
  logic [ROW_W-1:0]      rows_q;
  logic [ROW_W-1:0]      rows_eff;
  logic [ADDR_WIDTH-1:0] addr_cur;
  logic                  beat_last, head_last, row_last, final_beat;
  logic                  in_fire, start_acc;

  assign start_acc = (state_q == S_IDLE) && start;
  assign in_fire   = in_valid && in_ready;

  assign rows_eff = ((cfg_rows == '0) || ({1'b0, cfg_rows} > ROWS_EXT)) ? ROW_W'(ROWS) : cfg_rows;

  assign beat_last  = (beat_q == BEAT_W'(BPH - 1));
  assign head_last  = (head_q == HEAD_W'(HEADS - 1));
  assign row_last   = (row_q == rows_q - ROW_W'(1));
  assign final_beat = beat_last && head_last && row_last;

  assign addr_cur = ADDR_WIDTH'(head_q) * ADDR_WIDTH'(ROWS * BPH)
                  + ADDR_WIDTH'(row_q) * ADDR_WIDTH'(BPH)
                  + ADDR_WIDTH'(beat_q);

  always_ff @(posedge clk_p or posedge rst_p) begin
    if (rst_p) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    done     = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        busy     = 1'b1;
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready && final_beat) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        busy = 1'b1;
        if (out_valid && out_ready && out_last) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_p or posedge rst_p) begin
    if (rst_p) begin
      beat_q    <= '0;
      head_q    <= '0;
      row_q     <= '0;
      rows_q    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_head  <= '0;
    end else begin
      if (start_acc) begin
        rows_q <= rows_eff;
        beat_q <= '0;
        head_q <= '0;
        row_q  <= '0;
      end else if (in_fire) begin
        // input order: beat fastest, then head, then row
        if (final_beat) begin
          beat_q <= '0;
          head_q <= '0;
          row_q  <= '0;
        end else if (!beat_last) begin
          beat_q <= beat_q + BEAT_W'(1);
        end else begin
          beat_q <= '0;
          if (!head_last) begin
            head_q <= head_q + HEAD_W'(1);
          end else begin
            head_q <= '0;
            row_q  <= row_q + ROW_W'(1);
          end
        end
      end

      if (in_fire) begin
        out_data  <= in_data;
        out_addr  <= addr_cur;
        out_head  <= head_q;
        out_valid <= 1'b1;
        out_last  <= final_beat;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SPLIT_SCHED_PERF_EN
  always_ff @(posedge clk_p or posedge rst_p) begin
    if (rst_p) begin
      perf_stall <= '0;
    end else if (start_acc) begin
      perf_stall <= '0;
    end else if (busy && out_valid && !out_ready && (perf_stall != '1)) begin
      perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_split_head_scheduler.sv
// Directed bench for split_head_scheduler at default parameters; covers the stall counter
// when SPLIT_SCHED_PERF_EN is defined.
module tb_split_head_scheduler;

  logic         clk_p = 1'b0;
  logic         rst_p;
  logic         start;
  logic [7:0]   cfg_rows;
  logic         busy, done;
  logic         in_valid, in_ready;
  logic [127:0] in_data;
  logic         out_valid, out_ready;
  logic [127:0] out_data;
  logic [15:0]  out_addr;
  logic [3:0]   out_head;
  logic         out_last;
`ifdef SPLIT_SCHED_PERF_EN
  logic [31:0]  perf_stall;
`endif

  int n_vec = 0;
  int n_err = 0;

  split_head_scheduler dut (
    .clk_p     (clk_p),
    .rst_p     (rst_p),
    .start     (start),
    .cfg_rows  (cfg_rows),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_head  (out_head),
    .out_last  (out_last)
`ifdef SPLIT_SCHED_PERF_EN
    ,
    .perf_stall(perf_stall)
`endif
  );

  always #5 clk_p = ~clk_p;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int n);
    return {32'(n), ~32'(n), 32'(n) ^ 32'h5A5A_C3C3, 32'h1234_0000 + 32'(n)};
  endfunction

  // head-major destination of the n-th input beat (BPH=4, HEADS=12, ROWS=128)
  function automatic logic [15:0] exp_addr(input int n);
    int beat, head, row;
    beat = n % 4;
    head = (n / 4) % 12;
    row  = n / 48;
    return 16'(head * 512 + row * 4 + beat);
  endfunction

  task automatic start_pass(input logic [7:0] rows);
    @(posedge clk_p); #1;
    out_ready = 1'b1;
    start     = 1'b1;
    cfg_rows  = rows;
    @(posedge clk_p); #1;
    start     = 1'b0;
    cfg_rows  = 8'd77;
    chk("busy_after_start", 128'(busy), 128'(1));
  endtask

  task automatic stream(input int exp_beats, input int st_lo, input int st_hi,
                        input int restart_c, input bit spot, input bit lat);
    int in_idx = 0, out_idx = 0, done_cnt = 0, c = 0, after = 0;
    int last_in_c = -100, done_c = -1;
    bit prev_stall = 1'b0;
    logic [127:0] pd;
    logic [15:0]  pa;
    in_valid = 1'b1;
    while (after < 3 && c < exp_beats + 60) begin
      out_ready = (c >= st_lo && c <= st_hi) ? 1'b0 : 1'b1;
      in_data   = pat(in_idx);
      start     = (c == restart_c);
      cfg_rows  = (c == restart_c) ? 8'd5 : 8'd77;
      @(negedge clk_p);
      if (out_valid && !out_ready && busy) chk("stall_in_ready", 128'(in_ready), 128'(0));
      if (prev_stall) begin
        chk("hold_addr", 128'(out_addr), 128'(pa));
        chk("hold_data", out_data, pd);
      end
      prev_stall = out_valid && !out_ready;
      pa = out_addr;
      pd = out_data;
      if (out_valid && out_ready) begin
        chk("addr", 128'(out_addr), 128'(exp_addr(out_idx)));
        chk("head", 128'(out_head), 128'((out_idx / 4) % 12));
        chk("data", out_data, pat(out_idx));
        chk("last", 128'(out_last), 128'(out_idx == exp_beats - 1));
        if (spot && out_idx == 0)  chk("beat0_addr", 128'(out_addr), 128'(0));
        if (spot && out_idx == 4)  chk("beat4_addr", 128'(out_addr), 128'(512));
        if (spot && out_idx == 4)  chk("beat4_head", 128'(out_head), 128'(1));
        if (spot && out_idx == 48) chk("beat48_addr", 128'(out_addr), 128'(4));
        if (spot && out_idx == 95) chk("beat95_addr", 128'(out_addr), 128'(5639));
        if (spot && out_idx == 95) chk("beat95_head", 128'(out_head), 128'(11));
        if (spot && out_idx == 95) chk("beat95_last", 128'(out_last), 128'(1));
        out_idx++;
      end
      if (in_valid && in_ready) begin
        in_idx++;
        last_in_c = c;
      end
      if (done) begin
        done_cnt++;
        done_c = c;
      end
      if (done_cnt > 0) after++;
      c++;
      @(posedge clk_p); #1;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk("in_beats", 128'(in_idx), 128'(exp_beats));
    chk("out_beats", 128'(out_idx), 128'(exp_beats));
    chk("done_count", 128'(done_cnt), 128'(1));
    chk("busy_after_done", 128'(busy), 128'(0));
    if (lat) chk("done_latency", 128'(done_c - last_in_c), 128'(2));
  endtask

  initial begin
    int dn;
    rst_p     = 1'b1;
    start     = 1'b0;
    cfg_rows  = 8'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    #12;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_last", 128'(out_last), 128'(0));
    chk("rst_out_addr", 128'(out_addr), 128'(0));
    chk("rst_out_head", 128'(out_head), 128'(0));
    chk("rst_out_data", out_data, 128'(0));
    @(posedge clk_p); #1;
    rst_p = 1'b0;

    // two rows, full throughput, spot addresses and done latency
    start_pass(8'd2);
    stream(96, -1, -1, -1, 1'b1, 1'b1);

    // downstream stall early in a one-row pass
    start_pass(8'd1);
    stream(48, 3, 7, -1, 1'b0, 1'b1);

    // start during RUN must be ignored
    start_pass(8'd1);
    stream(48, -1, -1, 10, 1'b0, 1'b1);

    // zero and oversize row counts both mean ROWS
    start_pass(8'd0);
    stream(6144, -1, -1, -1, 1'b0, 1'b1);
    start_pass(8'd200);
    stream(6144, -1, -1, -1, 1'b0, 1'b1);

    // reset in the middle of a pass
    start_pass(8'd1);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_data = pat(k);
      @(posedge clk_p); #1;
    end
    chk("mid_out_valid", 128'(out_valid), 128'(1));
    rst_p = 1'b1;
    #1;
    chk("mrst_busy", 128'(busy), 128'(0));
    chk("mrst_done", 128'(done), 128'(0));
    chk("mrst_in_ready", 128'(in_ready), 128'(0));
    chk("mrst_out_valid", 128'(out_valid), 128'(0));
    chk("mrst_out_last", 128'(out_last), 128'(0));
    chk("mrst_out_addr", 128'(out_addr), 128'(0));
    chk("mrst_out_head", 128'(out_head), 128'(0));
    chk("mrst_out_data", out_data, 128'(0));
    @(posedge clk_p); #1;
    rst_p = 1'b0;
    dn = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_p);
      if (done || busy) dn++;
    end
    chk("mrst_no_done", 128'(dn), 128'(0));
    in_valid = 1'b0;
    start_pass(8'd1);
    stream(48, -1, -1, -1, 1'b0, 1'b1);

`ifdef SPLIT_SCHED_PERF_EN
    start_pass(8'd1);
    stream(48, 10, 16, -1, 1'b0, 1'b1);
    chk("perf_stall_7", 128'(perf_stall), 128'(7));
    start_pass(8'd1);
    chk("perf_stall_clr", 128'(perf_stall), 128'(0));
    stream(48, -1, -1, -1, 1'b0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
